agc_search_ctrl: RTL and testbench
==================================

AGC_SEARCH_CTRL -- requirements
Module: agc_search_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: cycles waited after every gain change before measuring (legal 1..255).
REQ-002 SHALL have parameter THRESH_HI, default 8'd200: peak level above which gain is reduced.
REQ-003 SHALL have parameter THRESH_LO, default 8'd100: peak level below which gain is raised (THRESH_LO < THRESH_HI).
REQ-004 SHALL have parameter MEAS_TIMEOUT, default 1024: max cycles waiting for peak_valid (legal 1..65535).
REQ-005 SHALL have parameter MAX_ADJ, default 8: adjust pulses allowed per search before error.
REQ-006 SHALL have parameter RELOCK_CNT, default 4: consecutive out-of-window measurements in LOCKED that trigger a new search.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 RESETn  input  1  reset; synchronous, active-low.
REQ-009 start  input  1  request a gain search; level sampled each cycle.
REQ-010 peak_valid  input  1  one-cycle strobe, peak_level valid.
REQ-011 peak_level  input  8  unsigned detected signal peak.
REQ-012 search_done  input  1  gain search datapath reports last step taken.
REQ-013 gain_rst_n  output  1  active-low one-cycle reset to the gain search datapath.
REQ-014 adjust  output  1  one-cycle gain step strobe.
REQ-015 up_dn  output  1  step direction: 1 raise gain, 0 lower gain; meaningful only with adjust.
REQ-016 busy  output  1  search in progress.
REQ-017 locked  output  1  gain settled and in use.
REQ-018 err  output  1  search failed (timeout or MAX_ADJ exceeded); sticky until next start.

Function
REQ-019 States SHALL be IDLE, CLEAR, SETTLE, MEASURE, DECIDE, LOCKED, ERROR; all outputs registered.
REQ-020 IDLE: start=1 -> CLEAR next cycle; err cleared on that transition.
REQ-021 CLEAR: exactly one cycle; gain_rst_n=0; settle counter and adj_cnt cleared; busy=1, locked=0 -> SETTLE.
REQ-022 SETTLE: counts SETTLE_CYC cycles; on the last cycle -> LOCKED if search_done=1, else -> MEASURE.
REQ-023 MEASURE: timeout counter runs from 0; first cycle with peak_valid=1 latches peak_level and -> DECIDE; counter reaching MEAS_TIMEOUT with no peak_valid -> ERROR.
REQ-024 DECIDE: latched level > THRESH_HI -> adjust=1, up_dn=0 for that single cycle, adj_cnt+1, -> SETTLE.
REQ-025 DECIDE: latched level < THRESH_LO -> adjust=1, up_dn=1 for that single cycle, adj_cnt+1, -> SETTLE.
REQ-026 DECIDE: THRESH_LO <= level <= THRESH_HI (bounds inclusive) -> no adjust, -> LOCKED.
REQ-027 DECIDE with adj_cnt already = MAX_ADJ and level out of window -> no adjust, -> ERROR.
REQ-028 adjust SHALL never be high in two consecutive cycles; adjust SHALL be high only in DECIDE.
REQ-029 LOCKED: locked=1, busy=0; each peak_valid out of window increments oow_cnt, in-window clears it; oow_cnt reaching RELOCK_CNT -> CLEAR (locked drops the same edge).
REQ-030 LOCKED: start=1 -> CLEAR (forced re-search); start has priority over an in-window peak_valid in the same cycle.
REQ-031 ERROR: err=1, busy=0, locked=0; start=1 -> CLEAR; else stay.
REQ-032 start SHALL be ignored in CLEAR, SETTLE, MEASURE, DECIDE.
REQ-033 search_done outside the last SETTLE cycle SHALL be ignored.
REQ-034 Counters SHALL saturate, never wrap; settle counter >= 8 bits, timeout counter >= 16 bits, adj_cnt and oow_cnt >= 4 bits.

Reset
REQ-035 RESETn=0 at a rising edge SHALL force IDLE, gain_rst_n=1, adjust=0, up_dn=0, busy=0, locked=0, err=0, all counters 0, latched level 0.
REQ-036 Reset mid-search SHALL abort with no adjust pulse emitted on or after the reset edge; reset SHALL override start in the same cycle.

Verification
REQ-037 SETTLE_CYC=4: start pulse -> gain_rst_n low 1 cycle, then 4 SETTLE cycles, then MEASURE; busy=1 throughout.
REQ-038 peak_level=250 then 50 on successive measurements -> adjust with up_dn=0, then adjust with up_dn=1; each adjust exactly 1 cycle, separated by >= 4+1 cycles.
REQ-039 peak_level=150 on first measurement -> no adjust, locked=1 within 1 cycle after DECIDE; levels 100 and 200 also lock (inclusive bounds).
REQ-040 search_done=1 at end of SETTLE after 7th adjust -> LOCKED without MEASURE; with MAX_ADJ=2 and levels always 250 -> err=1 after 2 adjusts.
REQ-041 No peak_valid for MEAS_TIMEOUT cycles -> err=1, busy=0; then start -> err=0, CLEAR.
REQ-042 In LOCKED, RELOCK_CNT=4: three out-of-window then one in-window -> stays locked; four consecutive out-of-window -> CLEAR; RESETn=0 during SETTLE -> all outputs at REQ-035 values next cycle.

Source files
------------

// File: rtl/agc_search_ctrl.sv
// AGC gain-search controller: steps gain until the measured peak sits inside
// [THRESH_LO, THRESH_HI], then holds lock and re-searches when the level drifts.
module agc_search_ctrl #(
  parameter int unsigned SETTLE_CYC   = 16,
  parameter logic [7:0]  THRESH_HI    = 8'd200,
  parameter logic [7:0]  THRESH_LO    = 8'd100,
  parameter int unsigned MEAS_TIMEOUT = 1024,
  parameter int unsigned MAX_ADJ      = 8,
  parameter int unsigned RELOCK_CNT   = 4
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic       start,
  input  logic       peak_valid,
  input  logic [7:0] peak_level,
  input  logic       search_done,
  output logic       gain_rst_n,
  output logic       adjust,
  output logic       up_dn,
  output logic       busy,
  output logic       locked,
  output logic       err
);

  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned TMO_W    = 16;
  localparam int unsigned CNT_W    = 8;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(MEAS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    ADJ_MAX     = CNT_W'(MAX_ADJ);
  localparam logic [CNT_W-1:0]    OOW_LAST    = CNT_W'(RELOCK_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCKED, S_ERROR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
  logic [TMO_W-1:0]    r_tmo_cnt, w_tmo_nxt;
  logic [CNT_W-1:0]    r_adj_cnt, w_adj_nxt;
  logic [CNT_W-1:0]    r_oow_cnt, w_oow_nxt;
  logic [7:0]          r_level, w_level_nxt;
  logic                r_gain_rst_n, r_adjust, r_up_dn, r_busy, r_locked, r_err;
  logic                w_gain_rst_n_nxt, w_adjust_nxt, w_up_dn_nxt;
  logic                w_busy_nxt, w_locked_nxt, w_err_nxt;
  logic                w_pk_hi, w_pk_oow, w_lvl_oow;

  assign w_pk_hi   = peak_level > THRESH_HI;
  assign w_pk_oow  = w_pk_hi || (peak_level < THRESH_LO);
  assign w_lvl_oow = (r_level > THRESH_HI) || (r_level < THRESH_LO);

  // The adjust decision is made as the peak is latched so the strobe is
  // registered yet coincides exactly with the DECIDE state.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = '0;
    w_tmo_nxt    = '0;
    w_adj_nxt    = r_adj_cnt;
    w_oow_nxt    = '0;
    w_level_nxt  = r_level;
    w_adjust_nxt = 1'b0;
    w_up_dn_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_adj_nxt   = '0;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle_cnt >= SETTLE_LAST) begin
          w_state_nxt = search_done ? S_LOCKED : S_MEASURE;
        end else begin
          w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
        end
      end
      S_MEASURE: begin
        if (peak_valid) begin
          w_level_nxt = peak_level;
          w_state_nxt = S_DECIDE;
          if (w_pk_oow && (r_adj_cnt < ADJ_MAX)) begin
            w_adjust_nxt = 1'b1;
            w_up_dn_nxt  = !w_pk_hi;
          end
        end else if (r_tmo_cnt >= TMO_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_DECIDE: begin
        if (!w_lvl_oow) begin
          w_state_nxt = S_LOCKED;
        end else if (r_adj_cnt < ADJ_MAX) begin
          w_adj_nxt   = r_adj_cnt + CNT_W'(1);
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_LOCKED: begin
        w_oow_nxt = r_oow_cnt;
        if (start) begin
          w_state_nxt = S_CLEAR;
        end else if (peak_valid) begin
          if (!w_pk_oow) begin
            w_oow_nxt = '0;
          end else if (r_oow_cnt >= OOW_LAST) begin
            w_state_nxt = S_CLEAR;
          end else begin
            w_oow_nxt = r_oow_cnt + CNT_W'(1);
          end
        end
      end
      S_ERROR: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_gain_rst_n_nxt = (w_state_nxt != S_CLEAR);
    w_busy_nxt       = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_SETTLE) ||
                       (w_state_nxt == S_MEASURE) || (w_state_nxt == S_DECIDE);
    w_locked_nxt     = (w_state_nxt == S_LOCKED);
    w_err_nxt        = (w_state_nxt == S_ERROR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_adj_cnt    <= '0;
      r_oow_cnt    <= '0;
      r_level      <= '0;
      r_gain_rst_n <= 1'b1;
      r_adjust     <= 1'b0;
      r_up_dn      <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_adj_cnt    <= w_adj_nxt;
      r_oow_cnt    <= w_oow_nxt;
      r_level      <= w_level_nxt;
      r_gain_rst_n <= w_gain_rst_n_nxt;
      r_adjust     <= w_adjust_nxt;
      r_up_dn      <= w_up_dn_nxt;
      r_busy       <= w_busy_nxt;
      r_locked     <= w_locked_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign gain_rst_n = r_gain_rst_n;
  assign adjust     = r_adjust;
  assign up_dn      = r_up_dn;
  assign busy       = r_busy;
  assign locked     = r_locked;
  assign err        = r_err;

endmodule

// File: tb/tb_agc_search_ctrl.sv
// Scoreboarded bench for agc_search_ctrl: expected gain-reset, adjust, lock and
// error events are queued as stimulus is driven and popped as the DUT emits them.
module tb_agc_search_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 20;
  localparam int unsigned MAXA   = 8;
  localparam int unsigned RELOCK = 4;

  localparam logic [2:0] EV_CLR  = 3'd0;
  localparam logic [2:0] EV_DN   = 3'd1;
  localparam logic [2:0] EV_UP   = 3'd2;
  localparam logic [2:0] EV_LOCK = 3'd3;
  localparam logic [2:0] EV_ERR  = 3'd4;

  logic       clk = 1'b0;
  logic       RESETn, start, peak_valid, search_done;
  logic [7:0] peak_level;
  logic       gain_rst_n, adjust, up_dn, busy, locked, err;

  int n_checks = 0;
  int n_errors = 0;
  int tb_adj   = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  agc_search_ctrl #(
    .SETTLE_CYC(SETTLE), .THRESH_HI(8'd200), .THRESH_LO(8'd100),
    .MEAS_TIMEOUT(TMO), .MAX_ADJ(MAXA), .RELOCK_CNT(RELOCK)
  ) dut (
    .clk(clk), .RESETn(RESETn), .start(start), .peak_valid(peak_valid),
    .peak_level(peak_level), .search_done(search_done), .gain_rst_n(gain_rst_n),
    .adjust(adjust), .up_dn(up_dn), .busy(busy), .locked(locked), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decision for one measurement given adjusts already taken.
  function automatic logic [2:0] model(input logic [7:0] lvl, input int adj);
    if (lvl > 8'd200) return (adj < int'(MAXA)) ? EV_DN : EV_ERR;
    if (lvl < 8'd100) return (adj < int'(MAXA)) ? EV_UP : EV_ERR;
    return EV_LOCK;
  endfunction

  task automatic sb_pop(input string tag, input logic [2:0] got);
    logic [2:0] e;
    check({tag, "_pending"}, 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(got), 32'(e));
    end
  endtask

  // Output monitor: event scoreboard plus adjust pulse-shape checks.
  int   cyc = 0;
  int   last_adj = -100;
  logic prev_adj = 1'b0, prev_lock = 1'b0, prev_err = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (adjust) begin
      check("adj_shape", 32'(!prev_adj && (cyc - last_adj >= int'(SETTLE) + 1)), 1);
      last_adj = cyc;
      sb_pop("adj_ev", up_dn ? EV_UP : EV_DN);
    end
    if (!gain_rst_n) sb_pop("clr_ev", EV_CLR);
    if (locked && !prev_lock) sb_pop("lock_ev", EV_LOCK);
    if (err && !prev_err) sb_pop("err_ev", EV_ERR);
    prev_adj  = adjust;
    prev_lock = locked;
    prev_err  = err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rst_n"}, gain_rst_n, 1);
    check({tag, "_adjust"}, adjust, 0);
    check({tag, "_up_dn"}, up_dn, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic start_search();
    exp_q.push_back(EV_CLR);
    start = 1'b1;
    step();
    start = 1'b0;
    check("clr_rst_n", gain_rst_n, 0);
    check("clr_busy", busy, 1);
    check("clr_locked", locked, 0);
    check("clr_err", err, 0);
    tb_adj = 0;
  endtask

  // Walks the settle window; start and early search_done must be ignored.
  task automatic settle_phase(input logic sd);
    for (int i = 0; i < int'(SETTLE); i++) begin
      step();
      check("settle_busy", busy, 1);
      check("settle_adjust", adjust, 0);
      check("settle_rst_n", gain_rst_n, 1);
      start       = (i == 0);
      search_done = (i == int'(SETTLE) - 1) ? sd : (i == 1);
    end
    if (sd) exp_q.push_back(EV_LOCK);
    step();
    start       = 1'b0;
    search_done = 1'b0;
    if (sd) begin
      check("sd_locked", locked, 1);
      check("sd_busy", busy, 0);
    end else begin
      check("meas_busy", busy, 1);
      check("meas_locked", locked, 0);
    end
  endtask

  task automatic measure(input logic [7:0] lvl, input int wait_n, input logic sd);
    logic [2:0] ev;
    logic       is_adj;
    for (int i = 0; i < wait_n; i++) begin
      step();
      check("meas_wait_busy", busy, 1);
    end
    ev     = model(lvl, tb_adj);
    is_adj = (ev == EV_DN) || (ev == EV_UP);
    exp_q.push_back(ev);
    peak_valid = 1'b1;
    peak_level = lvl;
    step();
    peak_valid = 1'b0;
    peak_level = 8'($urandom);
    check("dec_adjust", adjust, 32'(is_adj));
    if (is_adj) begin
      check("dec_up_dn", up_dn, 32'(ev == EV_UP));
      tb_adj++;
      settle_phase(sd);
    end else begin
      step();
      if (ev == EV_LOCK) begin
        check("lock_locked", locked, 1);
        check("lock_busy", busy, 0);
      end else begin
        check("err_err", err, 1);
        check("err_busy", busy, 0);
        check("err_locked", locked, 0);
      end
    end
  endtask

  task automatic locked_pv(input logic [7:0] lvl, input logic exp_clr);
    if (exp_clr) exp_q.push_back(EV_CLR);
    peak_valid = 1'b1;
    peak_level = lvl;
    step();
    peak_valid = 1'b0;
    if (exp_clr) begin
      check("relock_locked", locked, 0);
      check("relock_rst_n", gain_rst_n, 0);
      tb_adj = 0;
    end else begin
      check("lk_stay", locked, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0; start = 1'b1; peak_valid = 1'b0; peak_level = 8'd0; search_done = 1'b0;
    repeat (3) step();
    check_reset_outs("por");
    RESETn = 1'b0; start = 1'b0;
    step();
    RESETn = 1'b1;
    step();
    check_reset_outs("idle");

    // Down then up adjust, then a mid-window lock.
    start_search();
    settle_phase(1'b0);
    measure(8'd250, 0, 1'b0);
    measure(8'd50, 2, 1'b0);
    measure(8'd150, 1, 1'b0);

    // Drift tolerance and relock in LOCKED.
    locked_pv(8'd250, 1'b0);
    locked_pv(8'd50, 1'b0);
    locked_pv(8'd201, 1'b0);
    locked_pv(8'd150, 1'b0);
    locked_pv(8'd255, 1'b0);
    locked_pv(8'd0, 1'b0);
    locked_pv(8'd99, 1'b0);
    locked_pv(8'd201, 1'b1);
    settle_phase(1'b0);
    measure(8'd100, 0, 1'b0);

    // start wins over an in-window peak while locked.
    exp_q.push_back(EV_CLR);
    start = 1'b1; peak_valid = 1'b1; peak_level = 8'd150;
    step();
    start = 1'b0; peak_valid = 1'b0;
    check("force_locked", locked, 0);
    check("force_rst_n", gain_rst_n, 0);
    tb_adj = 0;
    settle_phase(1'b0);
    measure(8'd200, 3, 1'b0);

    // search_done after the 7th adjust locks without measuring.
    start_search();
    settle_phase(1'b0);
    for (int i = 0; i < 7; i++) measure((i % 2) ? 8'd50 : 8'd250, i % 3, 1'(i == 6));

    // Adjust budget exhausted.
    start_search();
    settle_phase(1'b0);
    for (int i = 0; i < int'(MAXA); i++) measure(8'd250, 0, 1'b0);
    measure(8'd250, 0, 1'b0);
    repeat (3) step();
    check("err_sticky", err, 1);
    check("err_idle_busy", busy, 0);

    // Measurement timeout boundary.
    start_search();
    settle_phase(1'b0);
    for (int i = 0; i < int'(TMO) - 1; i++) step();
    check("tmo_pre_busy", busy, 1);
    check("tmo_pre_err", err, 0);
    exp_q.push_back(EV_ERR);
    step();
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);

    // Reset during SETTLE overrides start.
    start_search();
    step();
    step();
    RESETn = 1'b0; start = 1'b1;
    step();
    check_reset_outs("rst_settle");
    RESETn = 1'b1; start = 1'b0;
    step();

    // Reset on the edge that would have produced an adjust.
    start_search();
    settle_phase(1'b0);
    peak_valid = 1'b1; peak_level = 8'd250; RESETn = 1'b0;
    step();
    peak_valid = 1'b0; RESETn = 1'b1;
    check_reset_outs("rst_dec");
    step();
    check("rst_dec_after_adj", adjust, 0);

    start_search();
    settle_phase(1'b0);
    measure(8'd150, 0, 1'b0);

    step();
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
